// File: rtl/vending_machine_multi.sv
// ============================================================================
// vending_machine_multi
//
// Multi-product vending controller. Accepts three coin denominations, vends
// one of NUM_PRODUCTS items with per-product price and stock, and returns
// change as unit pulses. Credit is exposed in binary and as 3-digit BCD for
// the 7-seg display path. All logic runs on the rising edge of sys_clk.
//
// Optional feature macro: AUTO_CHANGE_EN
//   defined   : after a vend, any remaining credit is paid out automatically
//   undefined : the remainder stays as credit; change only via cancel_in
//
// Ports:
//   sys_clk      in   1                  system clock
//   reset        in   1                  synchronous, active-high
//   coin_in      in   1                  coin strobe (acted on at 0->1)
//   coin_sel     in   2                  coin denomination (3 = invalid)
//   sel_in       in   1                  purchase strobe (acted on at 0->1)
//   sel_idx      in   IDX_W              product index for the purchase
//   cancel_in    in   1                  refund strobe (acted on at 0->1)
//   credit       out  CREDIT_W           current credit, binary
//   credit_bcd   out  12                 {hundreds,tens,ones}, 1 cycle behind
//   product_out  out  NUM_PRODUCTS       one-hot 1-cycle vend pulse
//   change_pulse out  1                  1-cycle pulse per CHANGE_UNIT paid
//   coin_reject  out  1                  1-cycle pulse: coin returned
//   deny         out  1                  1-cycle pulse: purchase refused
//   sold_out     out  NUM_PRODUCTS       level, stock[i] == 0
//   busy         out  1                  high while vending or paying change
// ============================================================================
module vending_machine_multi #(
    parameter int unsigned NUM_PRODUCTS = 4,
    parameter int unsigned CREDIT_W     = 8,
    parameter int unsigned CREDIT_MAX   = 95,
    parameter int unsigned COIN_V0      = 5,
    parameter int unsigned COIN_V1      = 10,
    parameter int unsigned COIN_V2      = 25,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int unsigned STOCK_W      = 4,
    parameter int unsigned INIT_STOCK   = 9,
    parameter int unsigned CHANGE_UNIT  = 5,
    parameter int unsigned CHANGE_GAP   = 4
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    coin_in,
    input  logic [1:0]              coin_sel,
    input  logic                    sel_in,
    input  logic [((NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1)-1:0] sel_idx,
    input  logic                    cancel_in,
    output logic [CREDIT_W-1:0]     credit,
    output logic [11:0]             credit_bcd,
    output logic [NUM_PRODUCTS-1:0] product_out,
    output logic                    change_pulse,
    output logic                    coin_reject,
    output logic                    deny,
    output logic [NUM_PRODUCTS-1:0] sold_out,
    output logic                    busy
);

    localparam int unsigned IDX_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;
    localparam int unsigned GAP_W = $clog2(CHANGE_GAP);
    localparam int unsigned SUM_W = CREDIT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VEND,
        S_CHANGE
    } state_t;

    state_t state, state_nxt;

    // Edge-detect history; reset to 1 so a strobe held high through reset
    // release is not mistaken for a new event.
    logic coin_hist, sel_hist, cancel_hist;
    logic coin_evt, sel_evt, cancel_evt;

    logic [CREDIT_W-1:0]     credit_nxt;
    logic [IDX_W-1:0]        vend_idx, vend_idx_nxt;
    logic [GAP_W-1:0]        gap_cnt, gap_nxt;
    logic [NUM_PRODUCTS-1:0] product_nxt;
    logic                    change_nxt, reject_nxt, deny_nxt;

    logic [STOCK_W-1:0]      stock [NUM_PRODUCTS];
    logic [CREDIT_W-1:0]     price_tab [NUM_PRODUCTS];

    logic                    sel_valid;
    logic [CREDIT_W-1:0]     sel_price, vend_price;
    logic [STOCK_W-1:0]      sel_stock;

    logic                    coin_valid, coin_ok;
    logic [SUM_W-1:0]        coin_val, coin_sum;

    // ------------------------------------------------------------------
    // Price table unpacked from the flat parameter (slice i = product i)
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_price
        assign price_tab[g] = PRICES[g*CREDIT_W +: CREDIT_W];
    end

    assign coin_evt   = coin_in   & ~coin_hist;
    assign sel_evt    = sel_in    & ~sel_hist;
    assign cancel_evt = cancel_in & ~cancel_hist;

    // Index lookups are done by compare-and-select so an out-of-range
    // sel_idx never addresses past the end of the tables.
    always_comb begin
        sel_valid  = 1'b0;
        sel_price  = '0;
        sel_stock  = '0;
        vend_price = '0;
        for (int unsigned k = 0; k < NUM_PRODUCTS; k++) begin
            if (sel_idx == IDX_W'(k)) begin
                sel_valid = 1'b1;
                sel_price = price_tab[k];
                sel_stock = stock[k];
            end
            if (vend_idx == IDX_W'(k)) begin
                vend_price = price_tab[k];
            end
        end
    end

    // Coin decode; the sum is one bit wider so an overflow cannot wrap
    // back under CREDIT_MAX.
    always_comb begin
        coin_valid = 1'b1;
        coin_val   = '0;
        case (coin_sel)
            2'd0:    coin_val = SUM_W'(COIN_V0);
            2'd1:    coin_val = SUM_W'(COIN_V1);
            2'd2:    coin_val = SUM_W'(COIN_V2);
            default: coin_valid = 1'b0;
        endcase
        coin_sum = {1'b0, credit} + coin_val;
        coin_ok  = coin_valid && (coin_sum <= SUM_W'(CREDIT_MAX));
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        credit_nxt   = credit;
        vend_idx_nxt = vend_idx;
        gap_nxt      = gap_cnt;
        product_nxt  = '0;
        change_nxt   = 1'b0;
        reject_nxt   = 1'b0;
        deny_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                // cancel > select > coin; a coin that loses is returned
                if (cancel_evt) begin
                    reject_nxt = coin_evt;
                    if (credit != '0) begin
                        state_nxt = S_CHANGE;
                        gap_nxt   = '0;
                    end
                end else if (sel_evt) begin
                    reject_nxt = coin_evt;
                    if (!sel_valid || (credit < sel_price)) begin
                        deny_nxt = 1'b1;
                    end else if (sel_stock != '0) begin
                        state_nxt    = S_VEND;
                        vend_idx_nxt = sel_idx;
                    end
                end else if (coin_evt) begin
                    if (coin_ok) begin
                        credit_nxt = coin_sum[CREDIT_W-1:0];
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end

            S_VEND: begin
                reject_nxt = coin_evt;
                for (int unsigned k = 0; k < NUM_PRODUCTS; k++) begin
                    product_nxt[k] = (vend_idx == IDX_W'(k));
                end
                credit_nxt = credit - vend_price;
                gap_nxt    = '0;
`ifdef AUTO_CHANGE_EN
                state_nxt  = (credit != vend_price) ? S_CHANGE : S_IDLE;
`else
                state_nxt  = S_IDLE;
`endif
            end

            S_CHANGE: begin
                reject_nxt = coin_evt;
                // Pulse on the first cycle after entry, then every CHANGE_GAP.
                if (gap_cnt == '0) begin
                    change_nxt = 1'b1;
                    gap_nxt    = GAP_W'(CHANGE_GAP - 1);
                    if (credit <= CREDIT_W'(CHANGE_UNIT)) begin
                        credit_nxt = '0;
                        state_nxt  = S_IDLE;
                    end else begin
                        credit_nxt = credit - CREDIT_W'(CHANGE_UNIT);
                    end
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state        <= S_IDLE;
            credit       <= '0;
            credit_bcd   <= '0;
            vend_idx     <= '0;
            gap_cnt      <= '0;
            product_out  <= '0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            deny         <= 1'b0;
            coin_hist    <= 1'b1;
            sel_hist     <= 1'b1;
            cancel_hist  <= 1'b1;
            for (int unsigned k = 0; k < NUM_PRODUCTS; k++) begin
                stock[k] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            credit_bcd   <= to_bcd(credit);
            vend_idx     <= vend_idx_nxt;
            gap_cnt      <= gap_nxt;
            product_out  <= product_nxt;
            change_pulse <= change_nxt;
            coin_reject  <= reject_nxt;
            deny         <= deny_nxt;
            coin_hist    <= coin_in;
            sel_hist     <= sel_in;
            cancel_hist  <= cancel_in;
            for (int unsigned k = 0; k < NUM_PRODUCTS; k++) begin
                if (product_nxt[k] && (stock[k] != '0)) begin
                    stock[k] <= stock[k] - STOCK_W'(1);
                end
            end
        end
    end

    always_comb begin
        sold_out = '0;
        for (int unsigned k = 0; k < NUM_PRODUCTS; k++) begin
            sold_out[k] = (stock[k] == '0);
        end
    end

    assign busy = (state != S_IDLE);

    function automatic logic [11:0] to_bcd(input logic [CREDIT_W-1:0] bin);
        int unsigned v;
        v = 32'(bin);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

endmodule

// File: tb/tb_vending_machine_multi.sv
// ============================================================================
// tb_vending_machine_multi
//
// Directed bench for vending_machine_multi. dut_a uses the default
// parameters; dut_b has three products priced {20,15,10} with one unit of
// stock each, to reach sold-out and an out-of-range product index.
// ============================================================================
module tb_vending_machine_multi;

    localparam int GAP  = 4;
    localparam int UNIT = 5;

    logic       clk = 1'b0;
    logic       reset;

    logic       coin_in, sel_in, cancel_in;
    logic [1:0] coin_sel, sel_idx;
    logic [7:0] credit;
    logic [11:0] credit_bcd;
    logic [3:0] product_out, sold_out;
    logic       change_pulse, coin_reject, deny, busy;

    logic       b_coin_in, b_sel_in, b_cancel_in;
    logic [1:0] b_coin_sel, b_sel_idx;
    logic [7:0] b_credit;
    logic [11:0] b_credit_bcd;
    logic [2:0] b_product_out, b_sold_out;
    logic       b_change_pulse, b_coin_reject, b_deny, b_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vending_machine_multi dut_a (
        .sys_clk(clk), .reset(reset),
        .coin_in(coin_in), .coin_sel(coin_sel),
        .sel_in(sel_in), .sel_idx(sel_idx), .cancel_in(cancel_in),
        .credit(credit), .credit_bcd(credit_bcd), .product_out(product_out),
        .change_pulse(change_pulse), .coin_reject(coin_reject), .deny(deny),
        .sold_out(sold_out), .busy(busy)
    );

    vending_machine_multi #(
        .NUM_PRODUCTS(3),
        .PRICES({8'd20, 8'd15, 8'd10}),
        .INIT_STOCK(1)
    ) dut_b (
        .sys_clk(clk), .reset(reset),
        .coin_in(b_coin_in), .coin_sel(b_coin_sel),
        .sel_in(b_sel_in), .sel_idx(b_sel_idx), .cancel_in(b_cancel_in),
        .credit(b_credit), .credit_bcd(b_credit_bcd), .product_out(b_product_out),
        .change_pulse(b_change_pulse), .coin_reject(b_coin_reject), .deny(b_deny),
        .sold_out(b_sold_out), .busy(b_busy)
    );

    typedef enum int {OP_NOP, OP_COIN, OP_SEL, OP_CANCEL} op_t;

    typedef struct {
        op_t op;
        int  arg;
        int  credit;
        int  reject;
        int  deny;
        int  product;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(op_t op, int arg, int cr, int rj, int dn, int pr);
        vec_t v;
        v.op = op; v.arg = arg; v.credit = cr;
        v.reject = rj; v.deny = dn; v.product = pr;
        return v;
    endfunction

    function automatic int bcd_of(int v);
        return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic coin_a(input int s, input int exp_credit, input int exp_rej, input string name);
        coin_in  = 1'b1;
        coin_sel = 2'(s);
        tick();
        coin_in  = 1'b0;
        chk({name, " credit"}, int'(credit), exp_credit);
        chk({name, " coin_reject"}, int'(coin_reject), exp_rej);
        tick();
    endtask

    // Follows a payout already in CHANGE: n pulses, first one first_lat
    // cycles from the call, then exactly GAP apart; credit tracked every
    // cycle. Optionally strobes a coin and a select at cycle coin_at.
    task automatic drain(input int n, input int first_lat, input int start,
                         input int coin_at, input string name);
        int cnt  = 0;
        int last = 0;
        int exp  = start;
        for (int c = 1; c <= n * GAP + 20; c++) begin
            if (c == coin_at) begin
                coin_in  = 1'b1;
                coin_sel = 2'd0;
                sel_in   = 1'b1;
                sel_idx  = 2'd0;
            end
            tick();
            if (change_pulse) begin
                cnt++;
                if (cnt == 1) chk({name, " first pulse latency"}, c, first_lat);
                else          chk({name, " pulse gap"}, c - last, GAP);
                last = c;
                exp  = exp - UNIT;
            end
            chk({name, " credit"}, int'(credit), exp);
            chk({name, " product_out"}, int'(product_out), 0);
            if (c == coin_at) begin
                chk({name, " coin_reject while busy"}, int'(coin_reject), 1);
                chk({name, " select ignored while busy"}, int'(deny), 0);
                coin_in = 1'b0;
                sel_in  = 1'b0;
            end
        end
        chk({name, " pulse count"}, cnt, n);
        chk({name, " busy after"}, int'(busy), 0);
    endtask

    initial begin
        int prev;
        int cnt;

        reset     = 1'b1;
        coin_in   = 1'b1;   // held high across reset release: must not count
        coin_sel  = 2'd1;
        sel_in    = 1'b0;  sel_idx   = 2'd0;
        cancel_in = 1'b0;
        b_coin_in = 1'b0;  b_coin_sel = 2'd0;
        b_sel_in  = 1'b0;  b_sel_idx  = 2'd0;
        b_cancel_in = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("reset credit", int'(credit), 0);
        chk("reset credit_bcd", int'(credit_bcd), 0);
        chk("reset product_out", int'(product_out), 0);
        chk("reset change_pulse", int'(change_pulse), 0);
        chk("reset coin_reject", int'(coin_reject), 0);
        chk("reset deny", int'(deny), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset sold_out", int'(sold_out), 0);
        chk("reset b sold_out", int'(b_sold_out), 0);
        reset = 1'b0;
        tick();
        chk("held strobe at release credit", int'(credit), 0);
        chk("held strobe at release reject", int'(coin_reject), 0);
        coin_in = 1'b0;
        tick();

        // ---------------- table: coins, purchases, limits ----------------
        tbl.push_back(mk(OP_COIN, 1, 10, 0, 0, 0));
        tbl.push_back(mk(OP_NOP,  0, 10, 0, 0, 0));
        tbl.push_back(mk(OP_COIN, 1, 20, 0, 0, 0));
        tbl.push_back(mk(OP_NOP,  0, 20, 0, 0, 0));
        tbl.push_back(mk(OP_SEL,  2, 20, 0, 0, 0));       // product 2 costs 20
        tbl.push_back(mk(OP_NOP,  0,  0, 0, 0, 4'b0100));
        tbl.push_back(mk(OP_NOP,  0,  0, 0, 0, 0));
        tbl.push_back(mk(OP_COIN, 3,  0, 1, 0, 0));       // invalid denomination
        tbl.push_back(mk(OP_NOP,  0,  0, 0, 0, 0));
        tbl.push_back(mk(OP_COIN, 0,  5, 0, 0, 0));
        tbl.push_back(mk(OP_NOP,  0,  5, 0, 0, 0));
        tbl.push_back(mk(OP_SEL,  3,  5, 0, 1, 0));       // 5 < 25
        tbl.push_back(mk(OP_NOP,  0,  5, 0, 0, 0));
        tbl.push_back(mk(OP_SEL,  0,  5, 0, 1, 0));       // 5 < 10
        tbl.push_back(mk(OP_NOP,  0,  5, 0, 0, 0));
        tbl.push_back(mk(OP_COIN, 2, 30, 0, 0, 0));
        tbl.push_back(mk(OP_NOP,  0, 30, 0, 0, 0));
        tbl.push_back(mk(OP_COIN, 2, 55, 0, 0, 0));
        tbl.push_back(mk(OP_NOP,  0, 55, 0, 0, 0));
        tbl.push_back(mk(OP_COIN, 2, 80, 0, 0, 0));
        tbl.push_back(mk(OP_NOP,  0, 80, 0, 0, 0));
        tbl.push_back(mk(OP_COIN, 1, 90, 0, 0, 0));
        tbl.push_back(mk(OP_NOP,  0, 90, 0, 0, 0));
        tbl.push_back(mk(OP_COIN, 0, 95, 0, 0, 0));       // exactly CREDIT_MAX
        tbl.push_back(mk(OP_NOP,  0, 95, 0, 0, 0));
        tbl.push_back(mk(OP_COIN, 0, 95, 1, 0, 0));       // would be 100
        tbl.push_back(mk(OP_NOP,  0, 95, 0, 0, 0));
        tbl.push_back(mk(OP_COIN, 2, 95, 1, 0, 0));
        tbl.push_back(mk(OP_NOP,  0, 95, 0, 0, 0));
        tbl.push_back(mk(OP_SEL,  3, 95, 0, 0, 0));       // product 3 costs 25
        tbl.push_back(mk(OP_NOP,  0, 70, 0, 0, 4'b1000));

        prev = 0;
        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_COIN:   begin coin_in = 1'b1; coin_sel = 2'(tbl[i].arg); end
                OP_SEL:    begin sel_in  = 1'b1; sel_idx  = 2'(tbl[i].arg); end
                OP_CANCEL: cancel_in = 1'b1;
                default:   ;
            endcase
            tick();
            coin_in = 1'b0; sel_in = 1'b0; cancel_in = 1'b0;
            chk($sformatf("vec%0d credit", i), int'(credit), tbl[i].credit);
            chk($sformatf("vec%0d coin_reject", i), int'(coin_reject), tbl[i].reject);
            chk($sformatf("vec%0d deny", i), int'(deny), tbl[i].deny);
            chk($sformatf("vec%0d product_out", i), int'(product_out), tbl[i].product);
            chk($sformatf("vec%0d change_pulse", i), int'(change_pulse), 0);
            chk($sformatf("vec%0d credit_bcd", i), int'(credit_bcd), bcd_of(prev));
            prev = tbl[i].credit;
        end

        // ---------------- remainder after a vend ----------------
`ifdef AUTO_CHANGE_EN
        chk("auto change busy", int'(busy), 1);
`else
        chk("remainder kept busy", int'(busy), 0);
        tick();
        chk("remainder kept credit", int'(credit), 70);
        cancel_in = 1'b1;
        tick();
        cancel_in = 1'b0;
        chk("cancel enters change busy", int'(busy), 1);
`endif
        drain(14, 1, 70, -1, "payout70");

        // ---------------- cancel refund with coins during payout ----------------
        coin_a(2, 25, 0, "t5 coin25");
        coin_a(1, 35, 0, "t5 coin10");
        cancel_in = 1'b1;
        tick();
        cancel_in = 1'b0;
        chk("t5 busy", int'(busy), 1);
        chk("t5 no pulse on entry", int'(change_pulse), 0);
        drain(7, 1, 35, 3, "t5 refund");

        // ---------------- same-cycle priority, then reset mid-change ----------------
        coin_a(1, 10, 0, "t6 coin a");
        coin_a(1, 20, 0, "t6 coin b");
        cancel_in = 1'b1;
        sel_in    = 1'b1; sel_idx  = 2'd0;
        coin_in   = 1'b1; coin_sel = 2'd0;
        tick();
        cancel_in = 1'b0; sel_in = 1'b0; coin_in = 1'b0;
        chk("t6 coin_reject", int'(coin_reject), 1);
        chk("t6 deny", int'(deny), 0);
        chk("t6 busy", int'(busy), 1);
        chk("t6 credit", int'(credit), 20);
        cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (change_pulse) cnt++;
            chk("t6 no vend", int'(product_out), 0);
        end
        chk("t6 pulses before reset", cnt, 2);
        chk("t6 credit before reset", int'(credit), 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6 reset credit", int'(credit), 0);
        chk("t6 reset busy", int'(busy), 0);
        chk("t6 reset change_pulse", int'(change_pulse), 0);
        tick();
        chk("t6 credit_bcd after reset", int'(credit_bcd), 0);
        cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (change_pulse) cnt++;
        end
        chk("t6 no pulses after reset", cnt, 0);
        chk("t6 credit stays 0", int'(credit), 0);

        // ---------------- dut_b: stock exhaustion and index range ----------------
        b_coin_in = 1'b1; b_coin_sel = 2'd1;
        tick();
        b_coin_in = 1'b0;
        chk("b credit 10", int'(b_credit), 10);
        tick();
        b_sel_in = 1'b1; b_sel_idx = 2'd0;
        tick();
        b_sel_in = 1'b0;
        chk("b vend1 deny", int'(b_deny), 0);
        chk("b vend1 busy", int'(b_busy), 1);
        tick();
        chk("b vend1 product_out", int'(b_product_out), 3'b001);
        chk("b vend1 credit", int'(b_credit), 0);
        chk("b sold_out after vend", int'(b_sold_out), 3'b001);
        tick();
        b_coin_in = 1'b1; b_coin_sel = 2'd1;
        tick();
        b_coin_in = 1'b0;
        chk("b credit 10 again", int'(b_credit), 10);
        tick();
        b_sel_in = 1'b1; b_sel_idx = 2'd0;
        tick();
        b_sel_in = 1'b0;
        chk("b sold-out deny", int'(b_deny), 0);
        chk("b sold-out busy", int'(b_busy), 0);
        tick();
        chk("b sold-out product_out", int'(b_product_out), 0);
        chk("b sold-out credit kept", int'(b_credit), 10);
        b_sel_in = 1'b1; b_sel_idx = 2'd3;
        tick();
        b_sel_in = 1'b0;
        chk("b out-of-range deny", int'(b_deny), 1);
        chk("b out-of-range credit", int'(b_credit), 10);
        tick();
        chk("b deny is one pulse", int'(b_deny), 0);
        chk("b out-of-range product_out", int'(b_product_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
